// File: rtl/timer_ctrl.sv
// timer_ctrl: memory-mapped down-counting timer with one-shot/auto-reload modes and maskable irq.
module timer_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t      state, state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset, count, bmask;
    logic        irqf, wr_ctrl, wr_preset, reload, set_irq, unused;
    assign bmask     = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
    assign wr_ctrl   = we && addr[3:2] == 2'd0;
    assign wr_preset = we && addr[3:2] == 2'd1;
    assign reload    = ctrl[2:1] == 2'b01;
    assign set_irq   = state == CNT && ctrl[0] && count == '0;
    assign unused    = ^{addr[31:4], addr[1:0]};
    always_comb begin
        state_nxt = state == IDLE ? (ctrl[0] ? LOAD : IDLE) :
                    state == LOAD ? CNT :
                    state == CNT  ? (!ctrl[0] ? IDLE : count == '0 ? INT : CNT) : IDLE;
    end
    // Software CTRL writes override the one-shot EN clear; a new IRQF set overrides the write-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            irqf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_ctrl && byteen[0])
                ctrl <= wdata[3:0];
            else if (state == INT && !reload)
                ctrl[0] <= 1'b0;
            if (wr_preset)
                preset <= (preset & ~bmask) | (wdata & bmask);
            if (state == LOAD)
                count <= preset;
            else if (state == CNT && ctrl[0] && count != '0)
                count <= count - 32'd1;
            if (set_irq)
                irqf <= 1'b1;
            else if ((state == INT && reload) || wr_ctrl || wr_preset)
                irqf <= 1'b0;
        end
    end
    assign rdata = addr[3:2] == 2'd0 ? {28'd0, ctrl} :
                   addr[3:2] == 2'd1 ? preset :
                   addr[3:2] == 2'd2 ? count : '0;
    assign irq   = irqf & ctrl[3];
endmodule
